// File: rtl/count_uart_pkg.sv
// Shared types, framing constants and the nibble-to-ASCII encoder used by the
// counter-to-UART bridge.
package count_uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    // Upper-case hex digit: 0-9 -> '0'..'9', 10-15 -> 'A'..'F'.
    function automatic logic [7:0] hex_to_ascii(input logic [3:0] nibble);
        logic [7:0] wide;
        wide = {4'h0, nibble};
        if (nibble < 4'd10) begin
            return 8'h30 + wide;
        end
        return 8'h41 + (wide - 8'd10);
    endfunction

endpackage

// File: rtl/count_uart_tx_sync_fifo.sv
// Small synchronous FIFO with show-ahead read data; a push while full is only
// accepted when a pop frees a slot on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      level_reg;
    logic [AW:0]      level_next;
    logic [DEPTH-1:0] we;
    logic             do_push;
    logic             do_pop;

    assign full    = (level_reg == (AW+1)'(DEPTH));
    assign empty   = (level_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr_reg];
    assign level   = level_reg;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
        assign we[gi] = do_push && (wr_ptr_reg == AW'(gi));
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (we[i]) begin
                mem[i] <= wr_data;
            end
        end
    end

    always_comb begin
        level_next = level_reg;
        case ({do_push, do_pop})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            level_reg <= level_next;
        end
    end

endmodule

// File: rtl/count_uart_tx.sv
// Logs every change of the 4-bit counter as an ASCII hex character and sends
// it out as an 8N1 serial frame on tx.
module count_uart_tx
    import count_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [3:0]                    count,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);

    logic [3:0]    prev_count_reg;
    logic          push;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    fifo_rd_data;
    logic          overflow_reg;

    tx_state_t     state_reg,   state_next;
    logic [CW-1:0] clk_cnt_reg, clk_cnt_next;
    logic [BW-1:0] bit_cnt_reg, bit_cnt_next;
    logic [7:0]    shift_reg,   shift_next;
    logic          tx_reg,      tx_next;
    logic          busy_reg,    busy_next;
    logic          bit_done;

    assign push = (count != prev_count_reg);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (hex_to_ascii(count)),
        .pop     (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_count_reg <= 4'h0;
            overflow_reg   <= 1'b0;
        end else begin
            prev_count_reg <= count;
            if (push && fifo_full && !pop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign bit_done = (clk_cnt_reg == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        pop          = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    shift_next   = fifo_rd_data;
                    clk_cnt_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                clk_cnt_next = clk_cnt_reg + 1'b1;
                if (bit_done) begin
                    clk_cnt_next = '0;
                    bit_cnt_next = '0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                clk_cnt_next = clk_cnt_reg + 1'b1;
                if (bit_done) begin
                    clk_cnt_next = '0;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    if (bit_cnt_reg == BW'(DATA_BITS - 1)) begin
                        state_next = STOP;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                clk_cnt_next = clk_cnt_reg + 1'b1;
                if (bit_done) begin
                    clk_cnt_next = '0;
                    state_next   = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line outputs follow the state being entered, so they are registered
        // yet line up with the state register.
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
        end
    end

    assign tx       = tx_reg;
    assign busy     = busy_reg;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_count_uart_tx.sv
// Directed bench for count_uart_tx: a serial monitor decodes frames on tx and
// compares them against characters queued when the count changes.
module tb_count_uart_tx;
    import count_uart_pkg::*;

    localparam int CPB        = 4;
    localparam int DEPTH      = 4;
    localparam int FRAME_CLKS = FRAME_BITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] count = 4'h0;
    logic       tx;
    logic       busy;
    logic       overflow;
    logic [2:0] fifo_level;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    bit         free_run = 1'b0;
    int         frames_done = 0;

    count_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count      (count),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_hex_char(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h41 && c <= 8'h46);
    endfunction

    // Serial monitor: one line per decoded frame.
    initial begin
        logic [9:0] bits;
        logic [7:0] rx;
        bit         form_ok;
        bit         busy_ok;
        bit         aborted;
        forever begin
            @(negedge clk);
            if (reset !== 1'b0 || tx !== 1'b0) continue;
            form_ok = 1'b1;
            busy_ok = 1'b1;
            aborted = 1'b0;
            bits    = '0;
            for (int cyc = 0; cyc < FRAME_CLKS; cyc++) begin
                if (cyc > 0) @(negedge clk);
                if (reset !== 1'b0) begin
                    aborted = 1'b1;
                    break;
                end
                if (busy !== 1'b1) busy_ok = 1'b0;
                if (cyc % CPB == 0) bits[cyc / CPB] = tx;
                else if (tx !== bits[cyc / CPB]) form_ok = 1'b0;
            end
            if (aborted) begin
                $display("frame aborted by reset at %0t", $time);
                continue;
            end
            @(negedge clk);
            if (reset === 1'b0) check("frame_end_idle", {30'd0, busy, tx}, 32'h1);
            if (bits[0] !== 1'b0 || bits[9] !== 1'b1) form_ok = 1'b0;
            rx = bits[8:1];
            $display("frame rx=%02h form_ok=%0d busy_ok=%0d at %0t", rx, form_ok, busy_ok, $time);
            check("frame_form", {31'd0, form_ok}, 32'h1);
            check("frame_busy_40", {31'd0, busy_ok}, 32'h1);
            if (free_run) begin
                check("frame_hex_char", {31'd0, is_hex_char(rx)}, 32'h1);
            end else begin
                check("frame_expected", {31'd0, exp_q.size() > 0}, 32'h1);
                if (exp_q.size() > 0) check("frame_data", {24'd0, rx}, {24'd0, exp_q.pop_front()});
            end
            frames_done++;
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        count = 4'h0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic change(input logic [3:0] v, input bit expect_frame);
        count = v;
        if (expect_frame) exp_q.push_back(hex_to_ascii(v));
        $display("drive count=%h", v);
    endtask

    task automatic wait_drain(input int max_cycles);
        int c = 0;
        while ((exp_q.size() != 0 || busy !== 1'b0) && c < max_cycles) begin
            @(negedge clk);
            c++;
        end
        repeat (2) @(negedge clk);
        check("drain_in_time", {31'd0, c < max_cycles}, 32'h1);
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int         peak;
        int         ov_first;
        bit         ov_stayed;
        int         max_level;
        bit         saw_busy;
        int         c;

        // 1: reset and quiet line while count holds 0
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_tx", {31'd0, tx}, 32'h1);
        check("rst_busy", {31'd0, busy}, 32'h0);
        check("rst_overflow", {31'd0, overflow}, 32'h0);
        check("rst_level", {29'd0, fifo_level}, 32'h0);
        saw_busy = 1'b0;
        repeat (50) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check("no_frame_on_zero", {31'd0, saw_busy}, 32'h0);

        // 2: single change 0->5, latency and frame
        @(negedge clk);
        change(4'h5, 1'b1);
        @(posedge clk); #1;
        check("lat_tx_edgeN", {31'd0, tx}, 32'h1);
        check("lat_level_edgeN", {29'd0, fifo_level}, 32'h1);
        @(posedge clk); #1;
        check("lat_tx_edgeN1", {31'd0, tx}, 32'h0);
        check("lat_busy_edgeN1", {31'd0, busy}, 32'h1);
        wait_drain(200);

        // 3: 0->A
        apply_reset();
        @(negedge clk);
        change(4'hA, 1'b1);
        wait_drain(200);
        check("a_overflow", {31'd0, overflow}, 32'h0);

        // 4: burst of five, then one more into a full FIFO
        peak = 0;
        for (int v = 1; v <= 5; v++) begin
            change(4'(v), 1'b1);
            @(negedge clk);
            if (int'(fifo_level) > peak) peak = int'(fifo_level);
        end
        check("burst_peak", peak, 4);
        check("burst_no_overflow", {31'd0, overflow}, 32'h0);
        change(4'h6, 1'b0);
        @(negedge clk);
        check("burst_overflow", {31'd0, overflow}, 32'h1);
        check("burst_level_full", {29'd0, fifo_level}, 32'h4);
        wait_drain(400);
        check("burst_overflow_sticky", {31'd0, overflow}, 32'h1);

        // 5: free-running counter
        apply_reset();
        free_run  = 1'b1;
        ov_first  = 0;
        ov_stayed = 1'b1;
        max_level = 0;
        for (int i = 1; i <= 300; i++) begin
            count = count + 4'h1;
            @(negedge clk);
            if (ov_first == 0 && overflow === 1'b1) ov_first = i;
            if (ov_first != 0 && overflow !== 1'b1) ov_stayed = 1'b0;
            if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
        end
        $display("free run: overflow first at cycle %0d, max level %0d", ov_first, max_level);
        check("free_ov_within_6", {31'd0, ov_first != 0 && ov_first <= 6}, 32'h1);
        check("free_ov_sticky", {31'd0, ov_stayed}, 32'h1);
        check("free_level_max", max_level, 4);
        apply_reset();
        free_run = 1'b0;

        // 6: reset in the middle of DATA
        @(negedge clk);
        change(4'h7, 1'b1);
        @(negedge clk);
        change(4'h8, 1'b1);
        c = 0;
        while (tx !== 1'b0 && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("mid_tx_fell", {31'd0, c < 10}, 32'h1);
        repeat (3 * CPB) @(negedge clk);
        check("mid_busy_before", {31'd0, busy}, 32'h1);
        check("mid_level_before", {29'd0, fifo_level}, 32'h1);
        reset = 1'b1;
        count = 4'h0;
        exp_q.delete();
        @(posedge clk); #1;
        check("mid_rst_tx", {31'd0, tx}, 32'h1);
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        check("mid_rst_level", {29'd0, fifo_level}, 32'h0);
        check("mid_rst_overflow", {31'd0, overflow}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        saw_busy = 1'b0;
        repeat (60) begin
            @(negedge clk);
            if (busy !== 1'b0) saw_busy = 1'b1;
        end
        check("mid_no_more_frames", {31'd0, saw_busy}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_uart_tx.md
Name: count_uart_tx

Overview:
Downstream consumer of the 4-bit free-running counter. It watches the counter's `count` bus and captures every value change into a small FIFO. Each captured value is serialized as an ASCII hex character on a UART-style TX line, 8N1 framing. It lets the counter's activity be observed on a single pin in simulation and on hardware.

Parameters:
CLKS_PER_BIT, 4, clk cycles per serial bit (>=2); frame = 10*CLKS_PER_BIT cycles
FIFO_DEPTH, 4, capture FIFO entries (power of 2, >=2)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
count  input  4  counter value from the counter stage
tx  output  1  serial line; idle high
busy  output  1  high while a frame is being shifted (START..STOP)
overflow  output  1  sticky; set when a change is dropped because the FIFO is full
fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of FIFO entries

Behaviour:
- Interface: single clock `clk`; `reset` is synchronous and active-high, sampled on the rising edge.
- Reset values:
  - tx=1, busy=0, overflow=0, fifo_level=0.
  - FIFO emptied, FSM=IDLE, prev_count=4'h0, bit/clock counters=0.
  - Because prev_count resets to 0, a count of 0 present immediately after reset is not logged.
- Change detect:
  - push = (count != prev_count), evaluated combinationally against the registered prev_count.
  - prev_count <= count every non-reset edge.
  - The entry is written on the same edge the change is seen.
- Encoding: entry stored as an 8-bit ASCII byte.
  - 0-9 -> 8'h30+count.
  - A-F -> 8'h41+(count-10).
- FIFO:
  - Push when full and no pop that edge: value dropped, overflow<=1 (sticky until reset).
  - Push and pop on the same edge while full: both happen, level unchanged, no overflow.
  - Pop on empty never occurs.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If FIFO non-empty: pop into shift register, go to START next edge.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles -> STOP after bit 7.
  - STOP: tx=1 for CLKS_PER_BIT cycles -> IDLE.
  - IDLE lasts at least one cycle between frames.
- Latency: change seen at edge N -> tx falls at edge N+1 when IDLE and the FIFO is empty.
- busy=1 exactly in START/DATA/STOP, i.e. 10*CLKS_PER_BIT cycles per frame.
- Output registering: tx and busy are registered (no glitches).
- Reset mid-frame: tx=1 and busy=0 from the next edge; the partial frame is abandoned and the FIFO is flushed.

Decomposition:
- Package `count_uart_pkg` holds:
  - state enum (IDLE/START/DATA/STOP)
  - FRAME_BITS=10 and DATA_BITS=8 constants
  - function `hex_to_ascii(4b)->8b`
- Natural sub-module: `sync_fifo` (parameterized WIDTH/DEPTH; push/pop/full/empty/level; same clk and synchronous active-high reset).
- count_uart_tx holds the change detector, overflow flag and TX FSM.

Test Plan:
1. Assert reset 2 cycles with count=0 -> tx=1, busy=0, overflow=0, fifo_level=0; no frame while count holds 0.
2. CLKS_PER_BIT=4, count 0->5 for one change -> tx low 1 cycle after the change edge; bits 0,1,0,1,0,1,1,0,0,1 each 4 cycles (0x35, '5'); busy high exactly 40 cycles.
3. count 0->A -> data bits 1,0,0,0,0,0,1,0 (0x41, 'A'); overflow stays 0.
4. count 1,2,3,4,5 on consecutive edges from idle -> fifo_level peaks at 4, overflow=0; then count=6 -> overflow=1; frames emitted '1','2','3','4','5', and '6' never appears.
5. Free-running counter (increments every clk, 10ns period) after reset release -> overflow set within 6 cycles and stays 1; fifo_level never exceeds 4; tx frames remain well-formed.
6. Assert reset mid-DATA of a frame -> next edge tx=1, busy=0, fifo_level=0, overflow=0; no further frames until count changes.
